// File: rtl/bcd_seq_addsub.sv
// ---------------------------------------------------------------------------
// bcd_seq_addsub
//   Multi-digit BCD adder/subtractor that walks the operands one digit per
//   clock, least-significant digit first, through a single digit adder.
//   Subtraction is done as A + (nine's complement of B) + carry, so the same
//   digit adder serves both operations.
//
// Ports
//   clk      in   rising-edge clock
//   nrst     in   asynchronous active-low reset
//   start    in   operation request, accepted in IDLE or DONE
//   sub      in   0: A+B+cin, 1: A-B-cin (cin is borrow-in)
//   a, b     in   4*NDIG-bit BCD operands, digit i at [4i+3:4i]
//   cin      in   carry-in / borrow-in
//   busy     out  high while digits are being processed
//   done     out  one-cycle pulse when the result is valid
//   sum      out  BCD result, held until the next accepted start
//   cout     out  add: decimal carry-out, sub: borrow-out (1 = negative)
//   invalid  out  some latched digit of a or b was greater than 9
// ---------------------------------------------------------------------------
module bcd_seq_addsub #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              sub,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              invalid
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_invalid;

    logic            w_accept;
    logic            w_last;
    logic [2*NDIG-1:0] w_dig_bad;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_b_eff;
    logic [4:0]      w_t;
    logic [4:0]      w_t_adj;
    logic            w_gt9;
    logic [3:0]      w_s;

    // A request is only honoured when no operation is in flight.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == IW'(NDIG - 1));

    // Per-digit range check on the incoming operands (flagged, not aborted).
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig_chk
            assign w_dig_bad[gi]        = (a[4*gi +: 4] > 4'd9);
            assign w_dig_bad[NDIG + gi] = (b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // ---------------- single-digit datapath ----------------
    assign w_a_dig = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_dig = r_b[{r_idx, 2'b00} +: 4];
    // Nine's complement wraps in 4 bits for out-of-range digits.
    assign w_b_eff = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
    assign w_t     = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {4'b0000, r_carry};
    assign w_gt9   = (w_t > 5'd9);
    assign w_t_adj = w_t + 5'd6;
    assign w_s     = w_gt9 ? w_t_adj[3:0] : w_t[3:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_sub     <= sub;
            // For subtraction the running carry is the inverted borrow.
            r_carry   <= sub ? ~cin : cin;
            r_idx     <= '0;
            r_sum     <= '0;
            r_invalid <= |w_dig_bad;
        end else if (r_state == S_RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_s;
            r_carry <= w_gt9;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= r_sub ? ~w_gt9 : w_gt9;
            end
        end
    end

    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_addsub
//   Directed and swept checks of bcd_seq_addsub with NDIG=4. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_seq_addsub;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        invalid;

    int n_checks;
    int n_errors;

    bcd_seq_addsub #(.NDIG(4)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Integer reference for valid-digit operands.
    task automatic model(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic c, output logic [15:0] rs, output logic rc);
        int r;
        if (!s) begin
            r  = bcd2int(x) + bcd2int(y) + int'(c);
            rc = (r >= 10000);
            rs = int2bcd(r % 10000);
        end else begin
            r  = bcd2int(x) - bcd2int(y) - int'(c);
            rc = (r < 0);
            rs = int2bcd(r < 0 ? r + 10000 : r);
        end
    endtask

    // Must be entered on a falling edge. Returns on the falling edge where
    // done is seen (or after a timeout), with results captured there.
    task automatic run_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic c, output logic [15:0] rs, output logic rc,
                          output logic rinv, output int lat, output int busy_cnt);
        sub = s; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("timeout_done", 32'(lat), 32'd4);
        rs = sum; rc = cout; rinv = invalid;
    endtask

    initial begin
        logic [15:0] rs, es;
        logic        rc, ec, rinv;
        int          lat, bc, pulses;
        logic [15:0] ra, rb;

        n_checks = 0;
        n_errors = 0;
        nrst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_inv", 32'(invalid), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // 1. 0999 + 0001
        run_op(1'b0, 16'h0999, 16'h0001, 1'b0, rs, rc, rinv, lat, bc);
        $display("add 0999+0001 cin=0 -> sum=%h cout=%0d inv=%0d lat=%0d", rs, rc, rinv, lat);
        check("t1_sum", 32'(rs), 32'h1000);
        check("t1_cout", 32'(rc), 32'd0);
        check("t1_inv", 32'(rinv), 32'd0);
        check("t1_lat", 32'(lat), 32'd4);
        check("t1_busy", 32'(bc), 32'd4);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_hold_sum", 32'(sum), 32'h1000);

        // 2. 9999 + 0000 + 1, then back-to-back start from DONE
        run_op(1'b0, 16'h9999, 16'h0000, 1'b1, rs, rc, rinv, lat, bc);
        $display("add 9999+0000 cin=1 -> sum=%h cout=%0d", rs, rc);
        check("t2_sum", 32'(rs), 32'h0000);
        check("t2_cout", 32'(rc), 32'd1);

        // 3. subtractions, started straight from DONE
        run_op(1'b1, 16'h1000, 16'h0001, 1'b0, rs, rc, rinv, lat, bc);
        $display("sub 1000-0001 cin=0 -> sum=%h cout=%0d lat=%0d", rs, rc, lat);
        check("t3a_lat_b2b", 32'(lat), 32'd4);
        check("t3a_busy_b2b", 32'(bc), 32'd4);
        check("t3a_sum", 32'(rs), 32'h0999);
        check("t3a_cout", 32'(rc), 32'd0);
        run_op(1'b1, 16'h0001, 16'h0002, 1'b0, rs, rc, rinv, lat, bc);
        $display("sub 0001-0002 cin=0 -> sum=%h cout=%0d", rs, rc);
        check("t3b_sum", 32'(rs), 32'h9999);
        check("t3b_cout", 32'(rc), 32'd1);

        // 4. invalid digit
        run_op(1'b0, 16'h000A, 16'h0000, 1'b0, rs, rc, rinv, lat, bc);
        $display("add 000A+0000 cin=0 -> sum=%h cout=%0d inv=%0d", rs, rc, rinv);
        check("t4_inv", 32'(rinv), 32'd1);
        check("t4_sum", 32'(rs), 32'h0010);
        check("t4_cout", 32'(rc), 32'd0);
        @(negedge clk);

        // 5. start during RUN is ignored
        sub = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pulses = 0;
        rs = '0; rc = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                start = 1'b1; sub = 1'b1; a = 16'h9999; b = 16'h8888; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                rs = sum; rc = cout;
            end
            @(negedge clk);
        end
        $display("add 1234+1111 with start in RUN -> sum=%h cout=%0d pulses=%0d", rs, rc, pulses);
        check("t5_pulses", 32'(pulses), 32'd1);
        check("t5_sum", 32'(rs), 32'h2345);
        check("t5_cout", 32'(rc), 32'd0);

        // 6. reset during the second RUN cycle
        sub = 1'b0; a = 16'h000A; b = 16'h0999; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        $display("reset mid-RUN -> busy=%0d done=%0d sum=%h cout=%0d inv=%0d", busy, done, sum, cout, invalid);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_sum", 32'(sum), 32'h0);
        check("t6_cout", 32'(cout), 32'd0);
        check("t6_inv", 32'(invalid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("t6_no_done", 32'(pulses), 32'd0);
        run_op(1'b0, 16'h0999, 16'h0001, 1'b0, rs, rc, rinv, lat, bc);
        $display("after reset add 0999+0001 -> sum=%h cout=%0d", rs, rc);
        check("t6_sum_after", 32'(rs), 32'h1000);
        check("t6_lat_after", 32'(lat), 32'd4);

        // Single-digit sweep against the integer model
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 10; x++) begin
                    for (int y = 0; y < 10; y++) begin
                        ra = 16'(x); rb = 16'(y);
                        model(s[0], ra, rb, c[0], es, ec);
                        run_op(s[0], ra, rb, c[0], rs, rc, rinv, lat, bc);
                        $display("sweep sub=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d", s, ra, rb, c, rs, rc);
                        check("sweep_sum", 32'(rs), 32'(es));
                        check("sweep_cout", 32'(rc), 32'(ec));
                    end
                end
            end
        end

        // Random multi-digit operands
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            model(1'(n % 2), ra, rb, 1'((n / 2) % 2), es, ec);
            run_op(1'(n % 2), ra, rb, 1'((n / 2) % 2), rs, rc, rinv, lat, bc);
            $display("rand sub=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d", n % 2, ra, rb, (n / 2) % 2, rs, rc);
            check("rand_sum", 32'(rs), 32'(es));
            check("rand_cout", 32'(rc), 32'(ec));
            check("rand_inv", 32'(rinv), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
